// File: rtl/comsys_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// comsys_pkg
// Shared ComSys framing constants. The framer, the receive-side frame
// synchronizer and the bench all use this package.
//   - sync_state_e : synchronizer state codes (HUNT / CHECK / SYNC)
//   - HEAD         : frame header pattern, MSB on the wire first
//   - HEAD_LEN, DATA_LEN, FRAME_LEN : frame geometry in bits
//   - CONFIRM_N_DEF, LOSS_N_DEF     : default lock / loss thresholds
//   - sat_inc      : 3-bit saturating increment used by the hit counter
// -----------------------------------------------------------------------------
package comsys_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        SYNC  = 2'd2
    } sync_state_e;

    localparam int          HEAD_LEN  = 6;
    localparam logic [5:0]  HEAD      = 6'b100101;
    localparam int          DATA_LEN  = 8;
    localparam int          FRAME_LEN = HEAD_LEN + DATA_LEN;

    // Both thresholds must fit the 3-bit hit counter (<= 7).
    localparam int unsigned CONFIRM_N_DEF = 3;
    localparam int unsigned LOSS_N_DEF    = 3;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/frame_sync_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// frame_sync_rx
// Receive-side frame synchronizer. Hunts for the 6-bit header in the
// recovered bitstream, confirms it over CONFIRM_N correctly spaced frames,
// then flywheels on frame timing, tolerating up to LOSS_N-1 missed headers.
// In SYNC each 8-bit payload is delivered with a one-cycle valid pulse.
//
// Ports
//   clk_sys     in   1  system clock, rising edge
//   reset       in   1  asynchronous active-low reset
//   bit_in      in   1  recovered serial data bit
//   bit_en      in   1  bit strobe; bit_in is consumed when high
//   data_out    out  8  last delivered payload byte (MSB = first bit received)
//   data_valid  out  1  one-cycle pulse when data_out updates
//   locked      out  1  high while in SYNC
//   sync_state  out  2  0=HUNT, 1=CHECK, 2=SYNC
//   hit_cnt     out  3  confirm count in CHECK, miss count in SYNC
// -----------------------------------------------------------------------------
module frame_sync_rx
    import comsys_pkg::*;
#(
    parameter int unsigned CONFIRM_N = CONFIRM_N_DEF,
    parameter int unsigned LOSS_N    = LOSS_N_DEF
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                bit_in,
    input  logic                bit_en,
    output logic [DATA_LEN-1:0] data_out,
    output logic                data_valid,
    output logic                locked,
    output logic [1:0]          sync_state,
    output logic [2:0]          hit_cnt
);

    // The oldest bit ever read is the first payload bit, seven bits back,
    // so the history register only needs DATA_LEN-1 stages.
    localparam int SH_W = DATA_LEN - 1;

    sync_state_e         r_state;
    logic [SH_W-1:0]     r_shreg;
    logic [3:0]          r_bit_cnt;
    logic [2:0]          r_hit_cnt;
    logic [DATA_LEN-1:0] r_data;
    logic                r_valid;
    logic                r_locked;

    sync_state_e         w_state_nxt;
    logic [SH_W-1:0]     w_shreg_nxt;
    logic [3:0]          w_bit_cnt_nxt;
    logic [2:0]          w_hit_nxt;
    logic [DATA_LEN-1:0] w_data_nxt;
    logic                w_valid_nxt;

    logic [HEAD_LEN-1:0] w_win;
    logic                w_hdr_match;
    logic                w_frame_end;
    logic                w_pay_last;
    logic [2:0]          w_hit_inc;

    // Header window includes the bit being accepted on this edge.
    assign w_win       = {r_shreg[HEAD_LEN-2:0], bit_in};
    assign w_hdr_match = (w_win == HEAD);
    assign w_frame_end = (r_bit_cnt == 4'(FRAME_LEN - 1));
    assign w_pay_last  = (r_bit_cnt == 4'(DATA_LEN - 1));
    assign w_hit_inc   = sat_inc(r_hit_cnt);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_hit_nxt     = r_hit_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;

        if (bit_en) begin
            w_shreg_nxt   = {r_shreg[SH_W-2:0], bit_in};
            w_bit_cnt_nxt = w_frame_end ? 4'd0 : r_bit_cnt + 4'd1;

            case (r_state)
                HUNT: begin
                    // Next accepted bit after a detection is payload bit 0.
                    w_bit_cnt_nxt = 4'd0;
                    if (w_hdr_match) begin
                        w_state_nxt = CHECK;
                        w_hit_nxt   = 3'd1;
                    end
                end

                CHECK: begin
                    if (w_frame_end) begin
                        if (w_hdr_match) begin
                            w_hit_nxt = w_hit_inc;
                            if (w_hit_inc == 3'(CONFIRM_N)) begin
                                w_state_nxt = SYNC;
                                w_hit_nxt   = 3'd0;
                            end
                        end else begin
                            // False lock: resume searching from the next bit,
                            // keeping the history already shifted in.
                            w_state_nxt = HUNT;
                            w_hit_nxt   = 3'd0;
                        end
                    end
                end

                SYNC: begin
                    if (w_pay_last) begin
                        w_data_nxt  = {r_shreg[DATA_LEN-2:0], bit_in};
                        w_valid_nxt = 1'b1;
                    end
                    if (w_frame_end) begin
                        if (w_hdr_match) begin
                            w_hit_nxt = 3'd0;
                        end else begin
                            w_hit_nxt = w_hit_inc;
                            if (w_hit_inc == 3'(LOSS_N)) begin
                                w_state_nxt = HUNT;
                                w_hit_nxt   = 3'd0;
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = HUNT;
                    w_hit_nxt   = 3'd0;
                end
            endcase
        end
    end

    // NOTE: reset is asynchronous; every register, including the data
    // output and the shift history, clears the moment reset drops.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_state   <= HUNT;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_hit_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values computed above regardless of statement order.
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_hit_cnt <= w_hit_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_locked  <= (w_state_nxt == SYNC);
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign locked     = r_locked;
    assign sync_state = r_state;
    assign hit_cnt    = r_hit_cnt;

endmodule

// File: tb/tb_frame_sync_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_frame_sync_rx
// Scoreboard bench for frame_sync_rx. A reference model works on the whole
// accepted-bit history and the position of the anchoring header; expected
// bytes go into a queue that a separate monitor drains on data_valid.
// -----------------------------------------------------------------------------
module tb_frame_sync_rx;
    import comsys_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b0;
    logic       bit_in  = 1'b0;
    logic       bit_en  = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic [1:0] sync_state;
    logic [2:0] hit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    frame_sync_rx dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .sync_state (sync_state),
        .hit_cnt    (hit_cnt)
    );

    initial forever #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         hist[$];      // every accepted bit since the last reset
    int         m_mode;       // 0 searching, 1 confirming, 2 locked
    int         m_anchor;     // history index of the last bit of the anchoring header
    int         m_hit;
    logic [7:0] exp_q[$];
    logic [7:0] last_byte;    // expected data_out between pulses

    function automatic bit hdr_at(int n);
        for (int k = 0; k < HEAD_LEN; k++) begin
            int  idx = n - (HEAD_LEN - 1) + k;
            bit  b   = (idx >= 0) ? hist[idx] : 1'b0;
            if (b != HEAD[HEAD_LEN-1-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        m_mode    = 0;
        m_hit     = 0;
        m_anchor  = 0;
        last_byte = 8'h00;
    endtask

    task automatic model_bit(input bit b);
        int n;
        int p;
        logic [7:0] byte_v;
        hist.push_back(b);
        n = hist.size() - 1;
        p = n - m_anchor;
        case (m_mode)
            0: if (hdr_at(n)) begin
                   m_mode = 1; m_anchor = n; m_hit = 1;
               end
            1: if (p % FRAME_LEN == 0) begin
                   if (hdr_at(n)) begin
                       m_hit = (m_hit < 7) ? m_hit + 1 : 7;
                       if (m_hit == int'(CONFIRM_N_DEF)) begin m_mode = 2; m_hit = 0; end
                   end else begin
                       m_mode = 0; m_hit = 0;
                   end
               end
            default: begin
                if (p % FRAME_LEN == DATA_LEN) begin
                    for (int k = 0; k < DATA_LEN; k++) byte_v[7-k] = hist[n-7+k];
                    exp_q.push_back(byte_v);
                    last_byte = byte_v;
                end
                if (p % FRAME_LEN == 0) begin
                    if (hdr_at(n)) m_hit = 0;
                    else begin
                        m_hit = (m_hit < 7) ? m_hit + 1 : 7;
                        if (m_hit == int'(LOSS_N_DEF)) begin m_mode = 0; m_hit = 0; end
                    end
                end
            end
        endcase
    endtask

    task automatic check_state();
        check("sync_state", 32'(sync_state), 32'(m_mode));
        check("locked", 32'(locked), 32'(m_mode == 2));
        check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
    endtask

    // ---------------- monitor ----------------
    int cyc     = 0;
    int last_v  = -1;
    int prev_v  = -1;
    int n_valid = 0;

    always @(posedge clk_sys) begin
        #1;
        cyc++;
        if (data_valid) begin
            n_valid++;
            prev_v = last_v;
            last_v = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: data_out %0h with no byte expected at %0t", data_out, $time);
            end else begin
                check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input bit b, input int gap);
        @(negedge clk_sys);
        bit_en = 1'b1;
        bit_in = b;
        model_bit(b);
        @(posedge clk_sys);
        #1;
        check_state();
        repeat (gap) begin
            @(negedge clk_sys);
            bit_en = 1'b0;
            bit_in = 1'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            bit_en = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [5:0] hdr, input logic [7:0] pay, input int gap);
        for (int i = 5; i >= 0; i--) send_bit(hdr[i], gap);
        for (int i = 7; i >= 0; i--) send_bit(pay[i], gap);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        bit_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk_sys);
        reset  = 1'b1;
        model_reset();
    endtask

    // ---------------- main sequence ----------------
    localparam logic [5:0] BAD_HEAD = 6'b100100;
    localparam logic [4:0] JUNK     = 5'b11011;

    initial begin
        int base;
        model_reset();

        // Reset held with toggling inputs: outputs stay cleared.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            bit_in = ~bit_in;
            bit_en = i[0];
            @(posedge clk_sys);
            #1;
            check("rst_data_out", 32'(data_out), 32'h0);
            check("rst_valid", 32'(data_valid), 32'h0);
            check("rst_locked", 32'(locked), 32'h0);
            check("rst_state", 32'(sync_state), 32'h0);
        end
        @(negedge clk_sys);
        bit_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk_sys);
        #1;
        check_state();

        // Junk prefix then clean frames, one bit every 4 cycles.
        base = n_valid;
        for (int i = 4; i >= 0; i--) send_bit(JUNK[i], 3);
        for (int f = 0; f < 6; f++) send_frame(HEAD, 8'hA5, 3);
        idle(4);
        check("clean_bytes", 32'(n_valid - base), 32'd4);
        check("valid_period", 32'(last_v - prev_v), 32'(FRAME_LEN * 4));

        // Flywheel: two missed headers hold lock, three drop it.
        send_frame(BAD_HEAD, 8'hA5, 3);
        send_frame(BAD_HEAD, 8'hA5, 3);
        send_frame(HEAD, 8'hA5, 1);
        for (int f = 0; f < 3; f++) send_frame(BAD_HEAD, 8'hA5, 1);
        for (int f = 0; f < 5; f++) send_frame(HEAD, 8'h3C, 0);
        idle(4);

        // Corrupted second header while confirming.
        do_reset();
        base = n_valid;
        send_frame(HEAD, 8'hA5, 3);
        send_frame(BAD_HEAD, 8'hA5, 3);
        check("check_no_bytes", 32'(n_valid - base), 32'd0);
        for (int f = 0; f < 6; f++) send_frame(HEAD, 8'hA5, 3);
        idle(4);

        // Randomized frames: random payloads, random header errors,
        // occasional slips, random strobe spacing including back-to-back.
        for (int f = 0; f < 40; f++) begin
            logic [5:0] h;
            h = HEAD;
            if ($urandom_range(0, 3) == 0) h[$urandom_range(0, 5)] = ~h[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) send_bit(1'($urandom), $urandom_range(0, 2));
            end
            for (int i = 5; i >= 0; i--) send_bit(h[i], $urandom_range(0, 2));
            for (int i = 7; i >= 0; i--) send_bit(1'($urandom), $urandom_range(0, 2));
        end
        idle(4);

        // Lock, stall mid-payload, then async reset between edges.
        do_reset();
        for (int f = 0; f < 10 && m_mode != 2; f++) send_frame(HEAD, 8'h96, 1);
        check("stall_locked_before", 32'(locked), 32'h1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            bit_en = 1'b0;
            bit_in = 1'($urandom);
            @(posedge clk_sys);
            #1;
            check("stall_state", 32'(sync_state), 32'(m_mode));
            check("stall_data", 32'(data_out), 32'(last_byte));
        end
        @(posedge clk_sys);
        #2;
        reset = 1'b0;
        #1;
        check("arst_data_out", 32'(data_out), 32'h0);
        check("arst_valid", 32'(data_valid), 32'h0);
        check("arst_locked", 32'(locked), 32'h0);
        check("arst_state", 32'(sync_state), 32'h0);
        check("arst_hit", 32'(hit_cnt), 32'h0);
        #1;
        reset = 1'b1;
        model_reset();
        base = n_valid;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1);
        check("arst_no_partial", 32'(n_valid - base), 32'd0);
        for (int f = 0; f < 5; f++) send_frame(HEAD, 8'h5A, 1);
        idle(6);

        check("pending_bytes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
